cdc_handshake_rx: RTL

- Destination-side, read end of a toggle (two-phase) req/ack clock-domain crossing.
- Lives entirely in the reading clock domain. Receives an asynchronous request toggle plus a data bus held stable by the writer-side block.
- Presents each word to a local consumer with a valid/read handshake.
- Returns an ack toggle to the writer domain only after the consumer has taken the word, so the crossing is fully back-pressured and loss-free.

---
 rtl/cdc_handshake_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cdc_handshake_rx.sv
// Read-side endpoint of a two-phase req/ack toggle crossing: synchronizes the request toggle,
// captures the held data word, and returns the ack toggle once the consumer has read the word.
// Optional accepted-word counter output rx_count is enabled by defining CDC_RX_STATS_EN.
module cdc_handshake_rx #(
   parameter int unsigned DATA_LEN    = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_toggle_in,
   input  logic [DATA_LEN-1:0] data_in,
   output logic                ack_toggle_out,
   input  logic                read_en,
   output logic [DATA_LEN-1:0] data_out,
   output logic                data_valid,
`ifdef CDC_RX_STATS_EN
   output logic                overrun,
   output logic [15:0]         rx_count
`else
   output logic                overrun
`endif
);

   typedef enum logic [0:0] {StIdle, StValid} state_e;

   state_e              state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                req_sync;
   logic                req_seen_q, req_seen_d;
   logic                req_edge;
   logic [DATA_LEN-1:0] data_q, data_d;
   logic                ack_q, ack_d;
   logic                overrun_q, overrun_d;
   logic                accept;

   // Raw toggle feeds only the first flop of the chain; data_in is never synchronized.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_toggle_in};
      end
   end

   assign req_sync = sync_q[SYNC_STAGES-1];
   assign req_edge = req_sync ^ req_seen_q;
   assign accept   = (state_q == StValid) && read_en;

   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      data_d     = data_q;
      ack_d      = ack_q;
      overrun_d  = overrun_q;
      unique case (state_q)
         StIdle: begin
            if (req_edge) begin
               data_d     = data_in;
               req_seen_d = req_sync;
               state_d    = StValid;
            end
         end
         StValid: begin
            // A new request here is left pending in req_edge and serviced after the read.
            if (req_edge) begin
               overrun_d = 1'b1;
            end
            if (read_en) begin
               ack_d   = ~ack_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         req_seen_q <= 1'b0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_out       = data_q;
   assign data_valid     = (state_q == StValid);
   assign ack_toggle_out = ack_q;
   assign overrun        = overrun_q;

`ifdef CDC_RX_STATS_EN
   logic [15:0] rx_count_q, rx_count_d;

   always_comb begin
      rx_count_d = rx_count_q;
      if (accept) begin
         rx_count_d = rx_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_count_q <= '0;
      end else begin
         rx_count_q <= rx_count_d;
      end
   end

   assign rx_count = rx_count_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
